// File: rtl/instruction_fetch_queue.sv
// ============================================================================
//  Module      : instruction_fetch_queue
//  Description : Fetch stage ahead of IF/ID. Owns the fetch PC, issues one
//                outstanding word request to a handshaked instruction memory
//                and buffers returned instructions in an in-order queue that
//                feeds decode. Honours decode stall and flushes on redirect.
//  Options     : define FETCH_PERF_CNT_EN to add perf_stall_cycles and
//                perf_discards counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_discards
`endif
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    fetch_pc_q, fetch_pc_d;
  logic [63:0]    req_pc_q, req_pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [63:0]    pc_mem_q   [DEPTH];
  logic [31:0]    inst_mem_q [DEPTH];

  logic           not_full;
  logic           req_fire;
  logic           push;
  logic           pop;

  // Handshake qualifiers; a request only issues when a slot is free for its response
  always_comb begin
    not_full = (count_q < CW'(DEPTH));
    imem_req = (state_q == ST_IDLE) && !reset && !redirect && not_full;
    req_fire = imem_req && imem_ack;
    push     = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    pop      = if_valid && !stall && !redirect;
  end

  // Head of queue and request address come straight from registers
  always_comb begin
    imem_addr = fetch_pc_q;
    if_valid  = (count_q != '0);
    if_inst   = if_valid ? inst_mem_q[rd_ptr_q] : NOP;
    if_pc     = if_valid ? pc_mem_q[rd_ptr_q]   : 64'h0;
  end

  // Next-state: redirect flushes everything and overrides the normal flow
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~64'h3;
      // An in-flight request that has not returned must be thrown away later
      if (state_q == ST_WAIT) begin
        state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT:    if (imem_rvalid) state_d = ST_IDLE;
        ST_DISCARD: if (imem_rvalid) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC and queue bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 64'h0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_disc_q, perf_disc_d;
  logic        discard_evt;

  // Saturating event counters for head-blocked cycles and dropped responses
  always_comb begin
    discard_evt  = imem_rvalid &&
                   (((state_q == ST_WAIT) && redirect) || (state_q == ST_DISCARD));
    perf_stall_d = perf_stall_q;
    perf_disc_d  = perf_disc_q;
    if (if_valid && stall && (perf_stall_q != 32'hFFFFFFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (discard_evt && (perf_disc_q != 32'hFFFFFFFF))
      perf_disc_d = perf_disc_q + 32'd1;
    perf_stall_cycles = perf_stall_q;
    perf_discards     = perf_disc_q;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'h0;
      perf_disc_q  <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_disc_q  <= perf_disc_d;
    end
  end
`endif

endmodule

`default_nettype wire
